// File: rtl/trial_sequencer.sv
// trial_sequencer: sequences trials (index, active window, goal/timeout end, rest gap) for one run
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   start_run   in   pulse, begins a run from IDLE or DONE
//   abort       in   synchronous return to IDLE, clears index and tallies
//   step_en     in   one network update step elapsed
//   goal_hit    in   agent reached goal (RUN only)
//   iTrial      out  current trial index, changes only when entering LOAD
//   active      out  high in RUN
//   trial_load  out  high in LOAD, iTrial is new and stable
//   trial_done  out  registered pulse in first REST cycle
//   rewarded    out  with trial_done: 1 = goal, 0 = timeout
//   steps_taken out  step count of the last finished trial
//   n_success   out  rewarded trials in the current run
//   run_done    out  high in DONE
`timescale 1ns/1ps
module trial_sequencer #(
   parameter int NTRIAL      = 260,
   parameter int MAX_STEPS   = 1000,
   parameter int REST_CYCLES = 16,
   parameter int STEP_W      = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_run,
   input  logic              abort,
   input  logic              step_en,
   input  logic              goal_hit,
   output logic [9:0]        iTrial,
   output logic              active,
   output logic              trial_load,
   output logic              trial_done,
   output logic              rewarded,
   output logic [STEP_W-1:0] steps_taken,
   output logic [9:0]        n_success,
   output logic              run_done
);
   localparam int RW = $clog2(REST_CYCLES + 1);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, REST, DONE} state_t;
   state_t state, state_n;
   logic [STEP_W-1:0] step_cnt;
   logic [RW-1:0] rest_cnt;
   logic goal, tmo, rest_end, last, start_ok;
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      goal     = state == RUN && goal_hit;
      tmo      = state == RUN && step_en && step_cnt == STEP_W'(MAX_STEPS - 1);
      rest_end = state == REST && rest_cnt == RW'(REST_CYCLES - 1);
      last     = iTrial == 10'(NTRIAL - 1);
      start_ok = start_run && (state == IDLE || state == DONE);
      state_n  = state;
      if (abort) state_n = IDLE;
      else
         unique case (state)
            IDLE:    state_n = start_run ? LOAD : IDLE;
            LOAD:    state_n = RUN;
            RUN:     state_n = (goal || tmo) ? REST : RUN;
            REST:    state_n = rest_end ? (last ? DONE : LOAD) : REST;
            DONE:    state_n = start_run ? LOAD : DONE;
            default: state_n = IDLE;
         endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         iTrial      <= '0;
         step_cnt    <= '0;
         rest_cnt    <= '0;
         steps_taken <= '0;
         n_success   <= '0;
         trial_done  <= 1'b0;
         rewarded    <= 1'b0;
      end else begin
         trial_done <= 1'b0;
         rewarded   <= 1'b0;
         if (abort) begin
            iTrial      <= '0;
            step_cnt    <= '0;
            rest_cnt    <= '0;
            steps_taken <= '0;
            n_success   <= '0;
         end else begin
            if (start_ok) begin
               iTrial    <= '0;
               n_success <= '0;
            end
            if (state == LOAD) step_cnt <= '0;
            if (state == RUN) begin
               if (goal) begin
                  trial_done  <= 1'b1;
                  rewarded    <= 1'b1;
                  rest_cnt    <= '0;
                  n_success   <= n_success == 10'(NTRIAL) ? n_success : n_success + 10'd1;
                  // a step landing in the goal cycle still counts toward this trial
                  steps_taken <= (step_en && step_cnt != '1) ? step_cnt + STEP_W'(1) : step_cnt;
               end else if (tmo) begin
                  trial_done  <= 1'b1;
                  rest_cnt    <= '0;
                  steps_taken <= STEP_W'(MAX_STEPS);
               end else if (step_en && step_cnt != '1) step_cnt <= step_cnt + STEP_W'(1);
            end
            if (state == REST) begin
               rest_cnt <= rest_end ? '0 : rest_cnt + RW'(1);
               if (rest_end && !last) iTrial <= iTrial + 10'd1;
            end
         end
      end
   assign active     = state == RUN;
   assign trial_load = state == LOAD;
   assign run_done   = state == DONE;
endmodule

// File: tb/tb_trial_sequencer.sv
// tb_trial_sequencer: scoreboard-driven bench for trial_sequencer
`timescale 1ns/1ps
module tb_trial_sequencer;
   localparam int NT = 6, MS = 4, RC = 3, SW = 8;
   logic clk = 0, reset = 1, start_run = 0, abort = 0, step_en = 0, goal_hit = 0;
   logic [9:0] iTrial, n_success;
   logic active, trial_load, trial_done, rewarded, run_done;
   logic [SW-1:0] steps_taken;
   int n_cmp = 0, n_err = 0;
   typedef struct packed {logic [9:0] it; logic rew; logic [SW-1:0] st; logic [9:0] ns;} exp_t;
   exp_t sb[$];
   exp_t e, got;
   trial_sequencer #(.NTRIAL(NT), .MAX_STEPS(MS), .REST_CYCLES(RC), .STEP_W(SW)) dut (
      .clk(clk), .reset(reset), .start_run(start_run), .abort(abort), .step_en(step_en),
      .goal_hit(goal_hit), .iTrial(iTrial), .active(active), .trial_load(trial_load),
      .trial_done(trial_done), .rewarded(rewarded), .steps_taken(steps_taken),
      .n_success(n_success), .run_done(run_done));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_for(input logic done_sel, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(done_sel ? run_done : trial_load) && n < 50);
   endtask
   task automatic goal_trial(input int it, input int ns, input int nst);
      sb.push_back(exp_t'{10'(it), 1'b1, SW'(nst), 10'(ns)});
      tick();
      step_en = 1;
      repeat (nst) tick();
      step_en = 0;
      goal_hit = 1;
      tick();
      goal_hit = 0;
   endtask
   task automatic test_reset();
      #2 reset = 0;
      #1;
      n_cmp++;
      if ({iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done} !== '0) begin
         n_err++;
         $display("FAIL reset_outputs: iTrial=%0d active=%b load=%b done=%b rew=%b steps=%0d nsucc=%0d run_done=%b, required all 0",
                  iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done);
      end
      tick();
      reset = 1;
      tick();
      n_cmp++;
      if (active !== 0 || trial_load !== 0) begin
         n_err++;
         $display("FAIL idle_after_reset: active=%b load=%b, required 0 0", active, trial_load);
      end
   endtask
   task automatic test_timeout();
      int n;
      start_run = 1;
      tick();
      start_run = 0;
      n_cmp++;
      if (trial_load !== 1 || active !== 0 || iTrial !== 0) begin
         n_err++;
         $display("FAIL load_latency: load=%b active=%b iTrial=%0d, required 1 0 0", trial_load, active, iTrial);
      end
      sb.push_back(exp_t'{10'd0, 1'b0, SW'(MS), 10'd0});
      step_en = 1;
      tick();
      n_cmp++;
      if (active !== 1) begin
         n_err++;
         $display("FAIL active_latency: active=%b, required 1", active);
      end
      n = 1;
      while (active && n < 20) begin
         tick();
         if (active) n++;
      end
      step_en = 0;
      n_cmp++;
      if (n != MS) begin
         n_err++;
         $display("FAIL active_cycles: got %0d, required %0d", n, MS);
      end
      n_cmp++;
      e = sb.size() != 0 ? sb.pop_front() : '1;
      got = {iTrial, rewarded, steps_taken, n_success};
      if (trial_done !== 1 || got !== e) begin
         n_err++;
         $display("FAIL timeout_done: done=%b got %h, required %h", trial_done, got, e);
      end
      wait_for(0, n);
      n_cmp++;
      if (n != RC || iTrial !== 1) begin
         n_err++;
         $display("FAIL rest_gap: wait=%0d iTrial=%0d, required %0d 1", n, iTrial, RC);
      end
   endtask
   task automatic test_goal();
      int n;
      sb.push_back(exp_t'{10'd1, 1'b1, SW'(3), 10'd1});
      tick();
      step_en = 1;
      tick();
      tick();
      goal_hit = 1;
      tick();
      step_en = 0;
      goal_hit = 0;
      n_cmp++;
      e = sb.size() != 0 ? sb.pop_front() : '1;
      got = {iTrial, rewarded, steps_taken, n_success};
      if (trial_done !== 1 || active !== 0 || got !== e) begin
         n_err++;
         $display("FAIL goal_done: done=%b active=%b got %h, required %h", trial_done, active, got, e);
      end
      wait_for(0, n);
      n_cmp++;
      if (n != RC || iTrial !== 2) begin
         n_err++;
         $display("FAIL goal_next: wait=%0d iTrial=%0d, required %0d 2", n, iTrial, RC);
      end
   endtask
   task automatic test_goal_timeout();
      int n;
      sb.push_back(exp_t'{10'd2, 1'b1, SW'(MS), 10'd2});
      tick();
      step_en = 1;
      repeat (MS - 1) tick();
      goal_hit = 1;
      tick();
      step_en = 0;
      goal_hit = 0;
      n_cmp++;
      e = sb.size() != 0 ? sb.pop_front() : '1;
      got = {iTrial, rewarded, steps_taken, n_success};
      if (trial_done !== 1 || got !== e) begin
         n_err++;
         $display("FAIL goal_wins: done=%b got %h, required %h", trial_done, got, e);
      end
      goal_hit = 1;
      step_en = 1;
      start_run = 1;
      wait_for(0, n);
      goal_hit = 0;
      step_en = 0;
      start_run = 0;
      n_cmp++;
      if (n != RC || iTrial !== 3 || n_success !== 2 || steps_taken !== SW'(MS)) begin
         n_err++;
         $display("FAIL rest_ignores: wait=%0d iTrial=%0d nsucc=%0d steps=%0d, required %0d 3 2 %0d",
                  n, iTrial, n_success, steps_taken, RC, MS);
      end
   endtask
   task automatic test_run_to_done();
      int n;
      for (int it = 3; it < NT; it++) begin
         goal_trial(it, it, it - 3);
         n_cmp++;
         e = sb.size() != 0 ? sb.pop_front() : '1;
         got = {iTrial, rewarded, steps_taken, n_success};
         if (trial_done !== 1 || got !== e) begin
            n_err++;
            $display("FAIL run_trial_%0d: done=%b got %h, required %h", it, trial_done, got, e);
         end
         if (it < NT - 1) wait_for(0, n);
      end
      wait_for(1, n);
      n_cmp++;
      if (n != RC || run_done !== 1 || iTrial !== 10'(NT - 1) || n_success !== 10'(NT - 1) || active !== 0) begin
         n_err++;
         $display("FAIL run_done: wait=%0d run_done=%b iTrial=%0d nsucc=%0d active=%b, required %0d 1 %0d %0d 0",
                  n, run_done, iTrial, n_success, active, RC, NT - 1, NT - 1);
      end
      repeat (4) tick();
      n_cmp++;
      if (run_done !== 1 || iTrial !== 10'(NT - 1) || n_success !== 10'(NT - 1) || trial_load !== 0) begin
         n_err++;
         $display("FAIL done_hold: run_done=%b iTrial=%0d nsucc=%0d load=%b, required 1 %0d %0d 0",
                  run_done, iTrial, n_success, trial_load, NT - 1, NT - 1);
      end
      start_run = 1;
      tick();
      start_run = 0;
      n_cmp++;
      if (trial_load !== 1 || iTrial !== 0 || n_success !== 0 || run_done !== 0) begin
         n_err++;
         $display("FAIL restart: load=%b iTrial=%0d nsucc=%0d run_done=%b, required 1 0 0 0",
                  trial_load, iTrial, n_success, run_done);
      end
   endtask
   task automatic test_abort();
      int n;
      for (int k = 0; k < 5; k++) begin
         goal_trial(k, k + 1, k % 3);
         n_cmp++;
         e = sb.size() != 0 ? sb.pop_front() : '1;
         got = {iTrial, rewarded, steps_taken, n_success};
         if (trial_done !== 1 || got !== e) begin
            n_err++;
            $display("FAIL pre_abort_%0d: done=%b got %h, required %h", k, trial_done, got, e);
         end
         wait_for(0, n);
      end
      n_cmp++;
      if (iTrial !== 5) begin
         n_err++;
         $display("FAIL pre_abort_index: iTrial=%0d, required 5", iTrial);
      end
      tick();
      step_en = 1;
      tick();
      tick();
      step_en = 0;
      abort = 1;
      tick();
      abort = 0;
      n_cmp++;
      if ({iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done} !== '0) begin
         n_err++;
         $display("FAIL abort_clear: iTrial=%0d active=%b load=%b done=%b rew=%b steps=%0d nsucc=%0d run_done=%b, required all 0",
                  iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done);
      end
      tick();
      n_cmp++;
      if (trial_done !== 0 || trial_load !== 0 || active !== 0) begin
         n_err++;
         $display("FAIL abort_idle: done=%b load=%b active=%b, required 0 0 0", trial_done, trial_load, active);
      end
   endtask
   task automatic test_reset_mid_rest();
      start_run = 1;
      tick();
      start_run = 0;
      goal_trial(0, 1, 1);
      n_cmp++;
      e = sb.size() != 0 ? sb.pop_front() : '1;
      got = {iTrial, rewarded, steps_taken, n_success};
      if (trial_done !== 1 || got !== e) begin
         n_err++;
         $display("FAIL pre_reset_trial: done=%b got %h, required %h", trial_done, got, e);
      end
      tick();
      #2 reset = 0;
      #1;
      n_cmp++;
      if ({iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done} !== '0) begin
         n_err++;
         $display("FAIL async_reset: iTrial=%0d active=%b load=%b done=%b rew=%b steps=%0d nsucc=%0d run_done=%b, required all 0",
                  iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done);
      end
      tick();
      reset = 1;
      goal_hit = 1;
      step_en = 1;
      repeat (3) tick();
      goal_hit = 0;
      step_en = 0;
      n_cmp++;
      if ({iTrial, active, trial_load, trial_done, rewarded, steps_taken, n_success, run_done} !== '0) begin
         n_err++;
         $display("FAIL idle_ignores: iTrial=%0d active=%b done=%b steps=%0d nsucc=%0d, required all 0",
                  iTrial, active, trial_done, steps_taken, n_success);
      end
   endtask
   initial begin
      test_reset();
      test_timeout();
      test_goal();
      test_goal_timeout();
      test_run_to_done();
      test_abort();
      test_reset_mid_rest();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
